// File: rtl/adaptive_fir_iir.sv
// adaptive_fir_iir: two-bank FIR with optional output feedback,
// valid/ready streams, round-half-up and saturation.
// Ports: clk, srst (sync, active high), ctrl (mode tag per sample),
// s_tdata/s_tvalid/s_tready (input stream),
// m_tdata/m_tvalid/m_tready (output stream),
// cfg_we/cfg_bank/cfg_addr/cfg_data (coefficient write port).
module adaptive_fir_iir #(
  parameter int DATA_W    = 14,
  parameter int TAPS      = 5,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int FB_DELAY  = 2
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       ctrl,
  input  logic signed [DATA_W-1:0]   s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic signed [DATA_W-1:0]   m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  input  logic                       cfg_we,
  input  logic                       cfg_bank,
  input  logic [$clog2(TAPS)-1:0]    cfg_addr,
  input  logic signed [COEF_W-1:0]   cfg_data
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = COEF_W + DATA_W;
  localparam int ACC_W  = PROD_W + AW + 2;

  localparam logic signed [ACC_W-1:0] SMAX =
    (ACC_W'(1) <<< (DATA_W-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic signed [ACC_W-1:0] RND  =
    ACC_W'(1) <<< (COEF_FRAC-1);

  logic en;
  logic take;
  logic flush;
  logic mode;
  logic v1;
  logic mode1;

  logic signed [DATA_W-1:0] dline  [TAPS-1];
  logic signed [DATA_W-1:0] taps_n [TAPS];
  logic signed [COEF_W-1:0] coef   [2][TAPS];
  logic signed [DATA_W-1:0] fb     [FB_DELAY];

  logic signed [ACC_W-1:0]  acc_n;
  logic signed [ACC_W-1:0]  acc1;
  logic signed [ACC_W-1:0]  fb_term;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shr;
  logic signed [DATA_W-1:0] y_sat;

  assign en       = !m_tvalid || m_tready;
  assign s_tready = en;
  assign take     = s_tvalid && en;
  assign flush    = ctrl != mode;

  // A mode change filters the new sample against zero history.
  always_comb begin
    taps_n[0] = s_tdata;
    for (int k = 1; k < TAPS; k++)
      taps_n[k] = flush ? '0 : dline[k-1];
    acc_n = '0;
    for (int k = 0; k < TAPS; k++)
      acc_n = acc_n + ACC_W'(PROD_W'(coef[ctrl][k]) *
                             PROD_W'(taps_n[k]));
  end

  always_comb begin
    fb_term = '0;
    if (mode1)
      fb_term = ACC_W'(fb[FB_DELAY-1]) <<< COEF_FRAC;
    sum = acc1 + fb_term + RND;
    shr = sum >>> COEF_FRAC;
    if (shr > SMAX)
      y_sat = SMAX[DATA_W-1:0];
    else if (shr < SMIN)
      y_sat = SMIN[DATA_W-1:0];
    else
      y_sat = shr[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      mode     <= 1'b0;
      mode1    <= 1'b0;
      v1       <= 1'b0;
      acc1     <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      for (int k = 0; k < TAPS-1; k++)
        dline[k] <= '0;
      for (int k = 0; k < FB_DELAY; k++)
        fb[k] <= '0;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < TAPS; k++)
          coef[b][k] <= '0;
    end else begin
      if (cfg_we && 32'(cfg_addr) < TAPS)
        coef[cfg_bank][cfg_addr] <= cfg_data;
      if (en) begin
        v1       <= take;
        m_tvalid <= v1;
        if (take) begin
          acc1  <= acc_n;
          mode1 <= ctrl;
          mode  <= ctrl;
          for (int k = 0; k < TAPS-1; k++)
            dline[k] <= taps_n[k];
        end
        if (v1)
          m_tdata <= y_sat;
        // The flush wins over the shift so the
        // new-mode sample never sees old outputs.
        if (take && flush) begin
          for (int k = 0; k < FB_DELAY; k++)
            fb[k] <= '0;
        end else if (v1) begin
          for (int k = FB_DELAY-1; k > 0; k--)
            fb[k] <= fb[k-1];
          fb[0] <= y_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_adaptive_fir_iir.sv
// tb_adaptive_fir_iir: scoreboard bench for adaptive_fir_iir.
// Directed cases push constants; random phase uses a sample model.
module tb_adaptive_fir_iir;

  localparam int DATA_W    = 14;
  localparam int TAPS      = 5;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 14;
  localparam int FB_DELAY  = 2;
  localparam int AW        = $clog2(TAPS);

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic ctrl = 1'b0;
  logic signed [DATA_W-1:0] s_tdata = '0;
  logic s_tvalid = 1'b0;
  logic s_tready;
  logic signed [DATA_W-1:0] m_tdata;
  logic m_tvalid;
  logic m_tready = 1'b1;
  logic cfg_we = 1'b0;
  logic cfg_bank = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic signed [COEF_W-1:0] cfg_data = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int cyc_q[$];
  int cyc = 0;
  int cur_exp = 0;
  bit lat_on = 1'b1;
  bit rnd_on = 1'b0;

  int mx[TAPS-1];
  int my[FB_DELAY];
  int mc[2][TAPS];
  bit mmode;

  adaptive_fir_iir #(
    .DATA_W(DATA_W), .TAPS(TAPS), .COEF_W(COEF_W),
    .COEF_FRAC(COEF_FRAC), .FB_DELAY(FB_DELAY)
  ) dut (
    .clk(clk), .srst(srst), .ctrl(ctrl),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .cfg_we(cfg_we), .cfg_bank(cfg_bank),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rnd_on) m_tready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (srst) begin
      exp_q.delete();
      cyc_q.delete();
    end else begin
      if (m_tvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          chk("m_tdata", m_tdata, exp_q[0]);
          if (m_tready) begin
            if (lat_on) chk("latency", cyc - cyc_q[0], 2);
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
          end
        end
      end
      if (s_tvalid && s_tready) begin
        exp_q.push_back(cur_exp);
        cyc_q.push_back(cyc);
      end
    end
  end

  function automatic void model_reset();
    for (int k = 0; k < TAPS-1; k++) mx[k] = 0;
    for (int k = 0; k < FB_DELAY; k++) my[k] = 0;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < TAPS; k++) mc[b][k] = 0;
    mmode = 1'b0;
  endfunction

  function automatic int model_step(input int x, input bit c);
    int t[TAPS];
    longint acc;
    longint r;
    if (c != mmode) begin
      for (int k = 0; k < TAPS-1; k++) mx[k] = 0;
      for (int k = 0; k < FB_DELAY; k++) my[k] = 0;
      mmode = c;
    end
    t[0] = x;
    for (int k = 1; k < TAPS; k++) t[k] = mx[k-1];
    acc = 0;
    for (int k = 0; k < TAPS; k++)
      acc += longint'(mc[c][k]) * longint'(t[k]);
    if (c) acc += longint'(my[FB_DELAY-1]) * (64'sd1 << COEF_FRAC);
    r = (acc + (64'sd1 << (COEF_FRAC-1))) >>> COEF_FRAC;
    if (r > 8191) r = 8191;
    if (r < -8192) r = -8192;
    for (int k = 0; k < TAPS-1; k++) mx[k] = t[k];
    for (int k = FB_DELAY-1; k > 0; k--) my[k] = my[k-1];
    my[0] = int'(r);
    return int'(r);
  endfunction

  task automatic do_reset();
    srst = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    srst = 1'b0;
    model_reset();
  endtask

  task automatic cfg(input bit b, input int a, input int d);
    cfg_we = 1'b1;
    cfg_bank = b;
    cfg_addr = AW'(a);
    cfg_data = COEF_W'(d);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (a < TAPS) mc[b][a] = d;
  endtask

  task automatic send(input int x, input bit c, input int e);
    bit ok;
    s_tdata = DATA_W'(x);
    ctrl = c;
    cur_exp = e;
    s_tvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    cfg_we = 1'b0;
  endtask

  initial begin
    int dx[5] = '{0, 0, 100, 100, 100};
    int de[5] = '{0, 0, 100, 0, 0};
    int ie[6] = '{10, 10, 20, 20, 30, 30};
    int ne[6] = '{-1, -1, -8192, -8192, -8192, -8192};
    int rx[3] = '{3, -3, 1};
    int re[3] = '{2, -1, 1};
    int x;
    bit rc;

    do_reset();
    @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_s_tready", s_tready, 1);
    @(posedge clk);
    #1;
    send(1000, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    cfg(0, 0, 16384);
    cfg(0, 1, -16384);
    cfg(1, 0, 16384);
    foreach (dx[i]) send(dx[i], 0, de[i]);
    foreach (ie[i]) send(10, 1, ie[i]);
    send(5, 0, 5);

    for (int i = 0; i < 6; i++) send(8191, 1, 8191);
    foreach (ne[i]) send(-8192, 1, ne[i]);

    cfg(0, 0, 8192);
    cfg(0, 1, 0);
    foreach (rx[i]) send(rx[i], 0, re[i]);

    cfg(0, 0, 16384);
    cfg_we = 1'b1;
    cfg_bank = 1'b0;
    cfg_addr = AW'(0);
    cfg_data = COEF_W'(8192);
    send(7, 0, 7);
    send(7, 0, 4);
    cfg(0, 7, 16384);
    send(7, 0, 4);

    send(9, 0, 5);
    srst = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = DATA_W'(99);
    @(posedge clk);
    #1;
    srst = 1'b0;
    s_tvalid = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_m_tdata", m_tdata, 0);
    chk("midrst_s_tready", s_tready, 1);
    @(posedge clk);
    #1;
    cfg(0, 0, 16384);
    cfg(0, 1, -16384);
    send(20, 0, 20);
    repeat (4) @(posedge clk);
    #1;

    do_reset();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < TAPS; k++)
        cfg(1'(b), k, int'($urandom_range(0, 32767)) - 16384);
    lat_on = 1'b0;
    rnd_on = 1'b1;
    rc = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) rc = ~rc;
      x = int'($urandom_range(0, 16383)) - 8192;
      for (int g = 0; g < 8; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        @(posedge clk);
        #1;
      end
      send(x, rc, model_step(x, rc));
    end
    rnd_on = 1'b0;
    #1;
    m_tready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adaptive_fir_iir.md
Name: adaptive_fir_iir

Overview:
Parametrised successor of the fixed 14-bit differentiator/integrator filter. It provides two runtime-loadable coefficient banks: bank 0 is pure FIR (differentiator); bank 1 is FIR plus output feedback y[n-FB_DELAY] (integrator). It adds valid/ready handshakes on both streams, rounding and saturation, and a clean history flush on mode change. It sits in the sample datapath between the ADC front-end formatter and the downstream decimator.

Parameters:
DATA_W, 14, signed input/output sample width
TAPS, 5, FIR taps per bank (>=2)
COEF_W, 16, signed coefficient width
COEF_FRAC, 14, fractional bits of coefficients
FB_DELAY, 2, feedback delay in samples for mode 1 (>=1)

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
ctrl  in  1  mode tag of the input sample: 0 = differentiator, 1 = integrator
s_tdata  in  DATA_W  signed input sample
s_tvalid  in  1  input sample valid
s_tready  out  1  input ready
m_tdata  out  DATA_W  signed filtered output
m_tvalid  out  1  output valid
m_tready  in  1  downstream ready
cfg_we  in  1  coefficient write strobe
cfg_bank  in  1  coefficient bank select
cfg_addr  in  clog2(TAPS)  tap index
cfg_data  in  COEF_W  signed coefficient value

Behaviour:
- Interface: one clock (clk); reset srst is synchronous and active-high.
- Reset: m_tvalid=0, m_tdata=0, s_tready=1 in the first cycle after reset. Delay line, feedback history, both coefficient banks and internal valids are all 0. Current mode is 0. A reset mid-operation drops all in-flight samples.
- Acceptance: a sample is accepted when s_tvalid && s_tready. ctrl is sampled only on acceptance.
- Pipeline: two stages with a global enable en = !m_tvalid || m_tready; s_tready = en.
  - Stage 1 updates the delay line with the new sample and registers acc1 = sum over k of c[mode][k]*x[n-k], full precision.
  - Stage 2 computes sum = acc1 + (mode ? fb[FB_DELAY-1] << COEF_FRAC : 0), rounds, saturates, and loads m_tdata.
- Latency: with no stalls, a sample accepted on cycle t appears with m_tvalid=1 on cycle t+2. A full pipeline accepts one sample per cycle.
- Bubbles: cycles with s_tvalid=0 do not shift the delay line or feedback history. History is per sample, not per cycle.
- Backpressure: while m_tvalid && !m_tready, m_tdata and all state hold and s_tready=0.
- Arithmetic:
  - Products are COEF_W+DATA_W bits.
  - The accumulator is COEF_W+DATA_W+clog2(TAPS)+2 bits, sized so it never overflows.
  - Rounding is round-half-up: add 2^(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC.
  - Saturation clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Feedback: fb is a FB_DELAY-deep shift register of saturated outputs. fb[0] holds the most recent output, and fb shifts only when stage 2 produces an output. In mode 0, fb is still loaded with the outputs but is not added.
- Mode change: when the ctrl of an accepted sample differs from the current mode, the delay line (older taps) and fb are cleared before that sample is processed. The sample is filtered with zero history and the mode updates. Samples already in stage 2 complete in their own mode.
- Coefficient writes:
  - On cfg_we, c[cfg_bank][cfg_addr] <= cfg_data.
  - A write affects samples that enter stage 1 on later cycles.
  - A write coinciding with acceptance uses the old value.
  - cfg_addr >= TAPS is ignored.

Test Plan:
- Differentiator: load bank0 = [16384, -16384, 0, 0, 0] (1.0, -1.0), ctrl=0, stream 0,0,100,100,100 -> m_tdata = 0,0,100,0,0, each exactly 2 cycles after its acceptance.
- Integrator: load bank1 = [16384, 0, 0, 0, 0], ctrl=1, constant x=10 -> 10,10,20,20,30,30 (y[n]=x[n]+y[n-2]).
- Saturation: integrator setup with x=8191 continuous -> 8191 from the 3rd output on, never wraps; x=-8192 -> -8192.
- Rounding: bank0 tap0 = 8192 (0.5) -> x=3 gives 2, x=-3 gives -1, x=1 gives 1.
- Handshake: random s_tvalid and m_tready at 50% -> the output sequence matches a golden sample-domain model. No sample is lost or duplicated, and m_tdata is stable while stalled.
- Mode switch and reset:
  - Integrator with output at 30, then a ctrl=0 sample x=5 with bank0 = [16384, -16384, ...] -> output 5 (history flushed).
  - Assert srst mid-stream -> m_tvalid=0 on the next cycle and the first post-reset output uses zero history.
